// File: rtl/score_event_sequencer_if.sv
// score_event_sequencer_if
//
// Purpose: bundles the upstream event handshake and the downstream BCD
// accumulator connection of score_event_sequencer into one interface.
//
// Signals:
//   evtValid      upstream event present this cycle
//   evtIsSub      1 = subtract, 0 = add
//   evtAmount     6-digit BCD amount, digit i = bits [4i:4i+3], digit 0 least significant
//   evtReady      sequencer can accept an event
//   evtError      one-cycle pulse after a handshake carrying a non-BCD digit
//   currentScore  accumulator result, same digit order as evtAmount
//   enableAdd     one-cycle add strobe to the accumulator
//   enableSub     one-cycle subtract strobe to the accumulator
//   amountOut     amount presented to the accumulator
//   busy          events queued or an issue in progress
//
// Modports:
//   master  event source / accumulator side (drives events and currentScore)
//   slave   the sequencer itself

interface score_event_sequencer_if;
    logic        evtValid;
    logic        evtIsSub;
    logic [0:23] evtAmount;
    logic        evtReady;
    logic        evtError;
    logic [0:23] currentScore;
    logic        enableAdd;
    logic        enableSub;
    logic [0:23] amountOut;
    logic        busy;

    modport master (
        output evtValid, evtIsSub, evtAmount, currentScore,
        input  evtReady, evtError, enableAdd, enableSub, amountOut, busy
    );

    modport slave (
        input  evtValid, evtIsSub, evtAmount, currentScore,
        output evtReady, evtError, enableAdd, enableSub, amountOut, busy
    );
endinterface

// File: rtl/score_event_sequencer.sv
// score_event_sequencer
//
// Purpose: queues add/subtract score events in a small FIFO and hands them
// one at a time to a downstream six-digit BCD accumulator. Each issued event
// produces a single-cycle enableAdd or enableSub pulse, followed by a settle
// cycle so the accumulator result is current before the next issue. Events
// whose amount contains a digit above 9 are consumed, dropped and flagged on
// evtError.
//
// Ports:
//   clk      rising-edge clock
//   resetN   synchronous active-low reset
//   bus      score_event_sequencer_if.slave (event handshake + accumulator side)
//
// Parameters:
//   DEPTH    FIFO entries, power of two, at least 2
//
// Configuration macro:
//   SCORE_SEQ_SAT_EN  when defined, a popped subtract whose amount exceeds
//                     currentScore issues currentScore instead, so the
//                     accumulator saturates at 000000 rather than wrapping.

module score_event_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    resetN,
    score_event_sequencer_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               fifo_sub [DEPTH];
    logic [0:23]        fifo_amt [DEPTH];

    logic               ready;
    logic               bcd_ok;
    logic               accept;
    logic               push;
    logic               pop;

    logic               enable_add;
    logic               enable_sub;
    logic               error_q;
    logic [0:23]        amount_q;

    logic               add_d;
    logic               sub_d;
    logic [0:23]        amount_d;

`ifdef SCORE_SEQ_SAT_EN
    // Reorders the port digit layout into a conventional packed value with
    // digit 5 in the top nibble, so a plain unsigned compare orders valid
    // BCD magnitudes most significant digit first.
    function automatic logic [23:0] magnitude(input logic [0:23] v);
        logic [23:0] m;
        m = '0;
        for (int i = 0; i < 6; i++) begin
            m[4*i +: 4] = v[4*i +: 4];
        end
        return m;
    endfunction
`endif

    // Ready deliberately ignores a same-cycle pop, so a full FIFO stalls a cycle.
    assign ready  = (count < CNT_W'(DEPTH));
    assign accept = bus.evtValid && ready;
    assign push   = accept && bcd_ok;
    assign pop    = (state == IDLE) && (count != '0);

    always_comb begin
        bcd_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.evtAmount[4*i +: 4] > 4'd9) begin
                bcd_ok = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count != '0) state_next = ISSUE;
            ISSUE:   state_next = SETTLE;
            SETTLE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered strobes and amount.
    always_comb begin
        add_d    = 1'b0;
        sub_d    = 1'b0;
        amount_d = amount_q;
        if (pop) begin
            add_d    = !fifo_sub[rd_ptr];
            sub_d    = fifo_sub[rd_ptr];
            amount_d = fifo_amt[rd_ptr];
`ifdef SCORE_SEQ_SAT_EN
            if (fifo_sub[rd_ptr] &&
                (magnitude(fifo_amt[rd_ptr]) > magnitude(bus.currentScore))) begin
                amount_d = bus.currentScore;
            end
`endif
        end
    end

    // FIFO storage has no reset; only the pointers and count define contents.
    always_ff @(posedge clk) begin
        if (resetN && push) begin
            fifo_sub[wr_ptr] <= bus.evtIsSub;
            fifo_amt[wr_ptr] <= bus.evtAmount;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            enable_add <= 1'b0;
            enable_sub <= 1'b0;
            error_q    <= 1'b0;
            amount_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            enable_add <= add_d;
            enable_sub <= sub_d;
            error_q    <= accept && !bcd_ok;
            amount_q   <= amount_d;
        end
    end

    assign bus.evtReady  = ready;
    assign bus.evtError  = error_q;
    assign bus.enableAdd = enable_add;
    assign bus.enableSub = enable_sub;
    assign bus.amountOut = amount_q;
    assign bus.busy      = (count != '0) || (state != IDLE);

endmodule
